requant_leaky_pack: RTL and testbench
=====================================

Name: requant_leaky_pack

Overview:
- Post-processing stage directly downstream of the 8-lane 1x1 conv PE array.
- Takes eight signed 32-bit accumulators (bias already added) per data_valid pulse.
- Per lane: optional leaky ReLU (slope ~0.1), fixed-point rescale, round, saturate to int8.
- Packs the 8 results into one 64-bit pixel word and buffers it in a small FIFO behind a valid/ready output, for the line buffer / writeback stage.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 4.
- STALL_MARGIN, 2, extra free entries reserved for upstream in-flight results when computing stall.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  acc_in valid (driven by the conv array's data_valid).
- acc_in[0:7]  input  32 each  signed accumulators; lane i becomes output byte i.
- scale  input  16  unsigned requant multiplier; quasi-static per layer.
- shift  input  5  arithmetic right shift amount, 0..31; quasi-static.
- relu_en  input  1  1 = leaky ReLU, 0 = linear (YOLO head layers); quasi-static.
- out_pixel  output  64  packed int8 lanes; lane i in bits [8i+7:8i].
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- stall  output  1  upstream must stop issuing new channels.
- overflow_err  output  1  sticky; a result was dropped because the FIFO was full.

Behaviour:
- Reset: out_valid=0, out_pixel=0, stall=0, overflow_err=0; pipeline valids cleared; FIFO emptied.
- Reset mid-operation discards all in-flight and buffered data.
- Pipeline: 3 registered stages. valid_in at cycle N -> FIFO write at end of cycle N+3. If the FIFO is empty and out_ready=1, out_valid rises in cycle N+4.
- S1 (leak), per lane:
  - If relu_en and acc<0: y = (acc * 13) >>> 7, floor, 36-bit intermediate.
  - Otherwise y = acc.
- S2 (scale): p = y * scale, signed x unsigned, 49-bit signed result.
- S3 (round/sat):
  - r = (p + (shift ? 1<<(shift-1) : 0)) >>> shift.
  - Clamp r to [-128, 127] and take the low 8 bits.
- Config: scale, shift and relu_en are sampled at each stage's own cycle. Changing them while the pipeline is non-empty is undefined; the controller changes them only between layers when idle.
- FIFO: standard circular buffer with count.
  - Simultaneous write and read when full is allowed: the read frees the slot.
  - Write while full without a simultaneous read: the result is dropped and overflow_err is set until rst.
- Credit logic:
  - inflight = number of valid S1..S3 stages.
  - stall = (count + inflight) >= FIFO_DEPTH - STALL_MARGIN. Registered, updated every cycle.
- out_pixel holds stable while out_valid && !out_ready.
- Back-to-back valid_in every cycle sustains 1 word/cycle when out_ready=1.

Optional Feature:
- Macro: REQUANT_SAT_STATS_EN.
- Defined:
  - Adds output sat_count (32-bit): counts lane results clamped at S3, summed across all 8 lanes each cycle.
  - Reset to 0; saturates at all-ones.
  - Adds input sat_clr (1), which clears the count synchronously; clear wins over an increment in the same cycle.
- Not defined: no such ports or logic exist.

Decomposition:
- Shared package: lane count (8), ACC_W=32, OUT_W=8, LEAK_NUM=13, LEAK_SHIFT=7, packed pixel typedef.
- Sub-module requant_lane: the S1-S3 arithmetic for one lane, instantiated 8x via generate.
- FIFO and credit logic live in the top module.

Test Plan:
- relu_en=1, scale=1, shift=3, all lanes acc=1000 -> every byte = 125 (0x7D), out_valid at cycle N+4.
- relu_en=1, scale=1, shift=0, acc=-1000 -> -102 (0x9A). Same with relu_en=0 -> -128 (saturated).
- scale=1, shift=0: lanes acc=100000 and -100000 with relu_en=0 -> 0x7F and 0x80.
- Lane-order check: acc_in[i]=i, scale=1, shift=0 -> out_pixel = 0x0706050403020100.
- Backpressure, FIFO_DEPTH=4: out_ready=0, one valid_in per cycle.
  - stall asserts once count+inflight reaches 2.
  - Keep driving inputs -> 5th result dropped, overflow_err=1.
  - Raise out_ready -> the first 4 words drain in order.
- rst asserted mid-stream with 2 words buffered -> next cycle out_valid=0, stall=0, and no stale word appears afterwards.

Source files
------------

// File: rtl/requant_leaky_pack_pkg.sv
// Shared constants, types and helpers for the requantise / leaky-ReLU / pack stage.
package requant_leaky_pack_pkg;

    localparam int LANES      = 8;
    localparam int ACC_W      = 32;
    localparam int OUT_W      = 8;
    localparam int LEAK_NUM   = 13;
    localparam int LEAK_SHIFT = 7;
    localparam int SCALE_W    = 16;
    localparam int SHIFT_W    = 5;
    localparam int LEAK_W     = 36;
    localparam int PROD_W     = 49;
    localparam int PIX_W      = LANES * OUT_W;

    typedef logic [PIX_W-1:0] pixel_t;

    // Number of set bits in a per-lane flag vector.
    function automatic logic [3:0] lane_popcount(input logic [LANES-1:0] flags);
        logic [3:0] total;
        total = 4'd0;
        for (int i = 0; i < LANES; i++) begin
            total = total + {3'd0, flags[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/requant_leaky_pack_lane.sv
// One lane of the requant pipeline: leak (S1), scale (S2), round/saturate (S3).
// With REQUANT_SAT_STATS_EN defined the lane also reports a registered clamp flag.
module requant_lane
    import requant_leaky_pack_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [ACC_W-1:0]   acc,
    input  logic [SCALE_W-1:0] scale,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               relu_en,
`ifdef REQUANT_SAT_STATS_EN
    output logic               sat,
`endif
    output logic [OUT_W-1:0]   res
);

    localparam logic signed [LEAK_W-1:0] LEAK_K = LEAK_W'(LEAK_NUM);
    localparam logic signed [PROD_W-1:0] SAT_HI = 49'sd127;
    localparam logic signed [PROD_W-1:0] SAT_LO = -49'sd128;

    logic signed [LEAK_W-1:0] acc_x_s;
    logic signed [LEAK_W-1:0] leak_mul_s;
    logic signed [LEAK_W-1:0] y_s;
    logic signed [LEAK_W-1:0] y_r;
    logic signed [PROD_W-1:0] y_ext_s;
    logic signed [PROD_W-1:0] sc_ext_s;
    logic signed [PROD_W-1:0] p_s;
    logic signed [PROD_W-1:0] p_r;
    logic signed [PROD_W-1:0] rnd_s;
    logic signed [PROD_W-1:0] sum_s;
    logic signed [PROD_W-1:0] r_s;
    logic        [OUT_W-1:0]  res_s;
    logic                     sat_s;
    logic        [OUT_W-1:0]  res_r;
    logic                     sat_r;

    // S1: negative inputs are multiplied by 13/128 (floor) when leaky ReLU is on.
    always_comb begin
        acc_x_s    = {{(LEAK_W-ACC_W){acc[ACC_W-1]}}, acc};
        leak_mul_s = acc_x_s * LEAK_K;
        if (relu_en && acc[ACC_W-1]) begin
            y_s = leak_mul_s >>> LEAK_SHIFT;
        end else begin
            y_s = acc_x_s;
        end
    end

    // S2: signed leak result times the unsigned layer multiplier.
    always_comb begin
        y_ext_s  = {{(PROD_W-LEAK_W){y_r[LEAK_W-1]}}, y_r};
        sc_ext_s = {{(PROD_W-SCALE_W){1'b0}}, scale};
        p_s      = y_ext_s * sc_ext_s;
    end

    // S3: round half up, arithmetic shift, clamp to the int8 range.
    always_comb begin
        if (shift == 5'd0) begin
            rnd_s = '0;
        end else begin
            rnd_s = 49'sd1 <<< (shift - 5'd1);
        end
        sum_s = p_r + rnd_s;
        r_s   = sum_s >>> shift;
        if (r_s > SAT_HI) begin
            res_s = 8'h7F;
            sat_s = 1'b1;
        end else if (r_s < SAT_LO) begin
            res_s = 8'h80;
            sat_s = 1'b1;
        end else begin
            res_s = r_s[OUT_W-1:0];
            sat_s = 1'b0;
        end
    end

    // Stage registers for S1, S2 and S3.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r   <= '0;
            p_r   <= '0;
            res_r <= '0;
            sat_r <= 1'b0;
        end else begin
            y_r   <= y_s;
            p_r   <= p_s;
            res_r <= res_s;
            sat_r <= sat_s;
        end
    end

    assign res = res_r;
`ifdef REQUANT_SAT_STATS_EN
    assign sat = sat_r;
`endif

endmodule

// File: rtl/requant_leaky_pack.sv
// Requantise eight conv accumulators to int8, pack into a 64-bit pixel word and
// buffer it in an output FIFO with credit-based stall towards the PE array.
// Optional: REQUANT_SAT_STATS_EN adds sat_clr / sat_count clamp statistics.
module requant_leaky_pack
    import requant_leaky_pack_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STALL_MARGIN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic [ACC_W-1:0]   acc_in [0:LANES-1],
    input  logic [SCALE_W-1:0] scale,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               relu_en,
    output logic [PIX_W-1:0]   out_pixel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               stall,
`ifdef REQUANT_SAT_STATS_EN
    input  logic               sat_clr,
    output logic [31:0]        sat_count,
`endif
    output logic               overflow_err
);

    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam int STALL_TH = FIFO_DEPTH - STALL_MARGIN;

    logic           v1_r, v2_r, v3_r;
    pixel_t         pix_s;
    pixel_t         mem_r [0:FIFO_DEPTH-1];
    logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]  count_r, count_nxt_s;
    logic [1:0]     inflight_s;
    logic [CW:0]    occ_s;
    logic           full_s, rd_en_s, wr_en_s, drop_s;
    logic           out_valid_r, stall_r, ovf_r;
`ifdef REQUANT_SAT_STATS_EN
    logic [LANES-1:0] lane_sat_s;
    logic [3:0]       sat_inc_s;
    logic [32:0]      sat_sum_s;
    logic [31:0]      sat_cnt_r;
`endif

    // Eight identical lanes; lane i lands in byte i of the packed word.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        requant_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .acc     (acc_in[g]),
            .scale   (scale),
            .shift   (shift),
            .relu_en (relu_en),
`ifdef REQUANT_SAT_STATS_EN
            .sat     (lane_sat_s[g]),
`endif
            .res     (pix_s[g*OUT_W +: OUT_W])
        );
    end

    // Valid flags travelling alongside the three lane stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end else begin
            v1_r <= valid_in;
            v2_r <= v1_r;
            v3_r <= v2_r;
        end
    end

    // FIFO handshake decode and occupancy seen by the credit check.
    always_comb begin
        full_s      = (count_r == CW'(FIFO_DEPTH));
        rd_en_s     = out_valid_r && out_ready;
        wr_en_s     = v3_r && (!full_s || rd_en_s);
        drop_s      = v3_r && full_s && !rd_en_s;
        count_nxt_s = count_r + CW'(wr_en_s) - CW'(rd_en_s);
        inflight_s  = {1'b0, v1_r} + {1'b0, v2_r} + {1'b0, v3_r};
        occ_s       = (CW+1)'(count_r) + (CW+1)'(inflight_s);
    end

    // Circular buffer storage, pointers and registered head-valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= pix_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r     <= count_nxt_s;
            out_valid_r <= (count_nxt_s != '0);
        end
    end

    // Stall reserves room for results still in the lane pipeline; overflow is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            stall_r <= (occ_s >= (CW+1)'(STALL_TH));
            ovf_r   <= ovf_r | drop_s;
        end
    end

`ifdef REQUANT_SAT_STATS_EN
    // Clamped lanes of the result leaving S3 this cycle, summed with headroom.
    always_comb begin
        sat_inc_s = lane_popcount(lane_sat_s & {LANES{v3_r}});
        sat_sum_s = {1'b0, sat_cnt_r} + 33'(sat_inc_s);
    end

    // Saturating clamp counter; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_r <= '0;
        end else if (sat_clr) begin
            sat_cnt_r <= '0;
        end else if (sat_sum_s[32]) begin
            sat_cnt_r <= '1;
        end else begin
            sat_cnt_r <= sat_sum_s[31:0];
        end
    end

    assign sat_count = sat_cnt_r;
`endif

    assign out_pixel    = mem_r[rd_ptr_r];
    assign out_valid    = out_valid_r;
    assign stall        = stall_r;
    assign overflow_err = ovf_r;

endmodule

// File: tb/tb_requant_leaky_pack.sv
// Scoreboard bench for requant_leaky_pack: stimulus pushes expected words, a
// negedge monitor models FIFO occupancy/credit and compares every cycle.
module tb_requant_leaky_pack;

    localparam int DEPTH  = 4;
    localparam int MARGIN = 2;

    typedef logic [31:0] acc_arr_t [0:7];
    typedef struct {
        int          cyc;
        logic [63:0] word;
        int          nsat;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    acc_arr_t    acc_in;
    logic [15:0] scale;
    logic [4:0]  shift;
    logic        relu_en;
    logic [63:0] out_pixel;
    logic        out_valid;
    logic        out_ready;
    logic        stall;
    logic        overflow_err;
`ifdef REQUANT_SAT_STATS_EN
    logic        sat_clr = 1'b0;
    logic [31:0] sat_count;
`endif

    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    pend_t       pend_q[$];
    logic [63:0] exp_q[$];
    bit          exp_stall = 1'b0;
    bit          exp_ovf = 1'b0;
    longint      exp_sat = 0;

    requant_leaky_pack #(.FIFO_DEPTH(DEPTH), .STALL_MARGIN(MARGIN)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .acc_in       (acc_in),
        .scale        (scale),
        .shift        (shift),
        .relu_en      (relu_en),
        .out_pixel    (out_pixel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .stall        (stall),
`ifdef REQUANT_SAT_STATS_EN
        .sat_clr      (sat_clr),
        .sat_count    (sat_count),
`endif
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // floor(a / 2**sh)
    function automatic longint fdiv(input longint a, input int sh);
        longint d, q;
        d = longint'(1) << sh;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic void ref_pixel(input acc_arr_t a, input bit relu, input int sc, input int sh,
                                      output logic [63:0] w, output int ns);
        longint y, p, r, half;
        w  = '0;
        ns = 0;
        for (int i = 0; i < 8; i++) begin
            y = longint'(signed'(a[i]));
            if (relu && y < 0) y = fdiv(y * 13, 7);
            p = y * longint'(sc);
            half = (sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0);
            r = fdiv(p + half, sh);
            if (r > 127) begin
                r = 127;
                ns++;
            end else if (r < -128) begin
                r = -128;
                ns++;
            end
            w[8*i +: 8] = 8'(r);
        end
    endfunction

    // Monitor / occupancy model: compare first, then apply this cycle's edge effects.
    always @(negedge clk) begin
        int    infl;
        bit    nxt_stall;
        pend_t e;
        if (mon_en) begin
            infl = 0;
            foreach (pend_q[k]) begin
                if (pend_q[k].cyc >= cyc - 3 && pend_q[k].cyc <= cyc - 1) infl++;
            end
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            chk("stall", 64'(stall), 64'(exp_stall));
            chk("overflow_err", 64'(overflow_err), 64'(exp_ovf));
`ifdef REQUANT_SAT_STATS_EN
            chk("sat_count", 64'(sat_count), 64'(exp_sat));
`endif
            nxt_stall = ((exp_q.size() + infl) >= (DEPTH - MARGIN));
            if (exp_q.size() != 0) begin
                chk("out_pixel", out_pixel, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
            if (pend_q.size() != 0 && pend_q[0].cyc == cyc - 3) begin
                e = pend_q.pop_front();
                exp_sat = exp_sat + e.nsat;
                if (exp_sat > 64'hFFFF_FFFF) exp_sat = 64'hFFFF_FFFF;
                if (exp_q.size() < DEPTH) exp_q.push_back(e.word);
                else exp_ovf = 1'b1;
            end
            if (rst) begin
                exp_q.delete();
                pend_q.delete();
                exp_stall = 1'b0;
                exp_ovf   = 1'b0;
                exp_sat   = 0;
            end else begin
                exp_stall = nxt_stall;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step();
        valid_in = 1'b0;
    endtask

    task automatic issue(input acc_arr_t a, input bit use_ovr, input logic [63:0] ovr);
        pend_t       e;
        logic [63:0] w;
        int          ns;
        step();
        acc_in   = a;
        valid_in = 1'b1;
        ref_pixel(a, relu_en, int'(scale), int'(shift), w, ns);
        e.cyc  = cyc;
        e.word = use_ovr ? ovr : w;
        e.nsat = ns;
        pend_q.push_back(e);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (k < 100 && (pend_q.size() != 0 || exp_q.size() != 0)) begin
            step();
            valid_in  = 1'b0;
            out_ready = 1'b1;
            k++;
        end
        if (k >= 100) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout: pending=%0d buffered=%0d required=0", pend_q.size(), exp_q.size());
        end
        idle();
        out_ready = 1'b1;
    endtask

    initial begin
        acc_arr_t a;
        rst       = 1'b1;
        valid_in  = 1'b0;
        out_ready = 1'b1;
        relu_en   = 1'b1;
        scale     = 16'd1;
        shift     = 5'd3;
        foreach (a[i]) a[i] = 32'd0;
        acc_in = a;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pixel", out_pixel, 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_overflow", 64'(overflow_err), 64'd0);
        mon_en = 1'b1;
        step();
        rst = 1'b0;

        // Directed vectors with hand-computed expectations.
        foreach (a[i]) a[i] = 32'd1000;
        issue(a, 1'b1, 64'h7D7D_7D7D_7D7D_7D7D);
        wait_idle();
        shift = 5'd0;
        foreach (a[i]) a[i] = 32'hFFFF_FC18;
        issue(a, 1'b1, 64'h9A9A_9A9A_9A9A_9A9A);
        wait_idle();
        relu_en = 1'b0;
        issue(a, 1'b1, 64'h8080_8080_8080_8080);
        wait_idle();
        foreach (a[i]) a[i] = (i % 2 == 0) ? 32'h0001_86A0 : 32'hFFFE_7960;
        issue(a, 1'b1, 64'h807F_807F_807F_807F);
        wait_idle();
        foreach (a[i]) a[i] = 32'(i);
        issue(a, 1'b1, 64'h0706_0504_0302_0100);
        wait_idle();

        // Backpressure: five back-to-back results into a 4-deep FIFO, consumer stalled.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            foreach (a[i]) a[i] = 32'(k * 16 + i);
            issue(a, 1'b0, 64'd0);
        end
        repeat (6) idle();
        chk("bp_overflow", 64'(overflow_err), 64'd1);
        chk("bp_stall", 64'(stall), 64'd1);
        chk("bp_head", out_pixel, 64'h0706_0504_0302_0100);
        wait_idle();

        // Reset mid-stream: two words buffered, two more in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            foreach (a[i]) a[i] = 32'(100 + k * 8 + i);
            issue(a, 1'b0, 64'd0);
        end
        repeat (4) idle();
        for (int k = 0; k < 2; k++) begin
            foreach (a[i]) a[i] = 32'(50 + k * 8 + i);
            issue(a, 1'b0, 64'd0);
        end
        step();
        valid_in = 1'b0;
        rst      = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_stall", 64'(stall), 64'd0);
        chk("mrst_overflow", 64'(overflow_err), 64'd0);
        chk("mrst_out_pixel", out_pixel, 64'd0);
        repeat (8) idle();

        // Randomised layers against the reference model.
        for (int b = 0; b < 8; b++) begin
            relu_en = 1'($urandom_range(0, 1));
            case (b % 3)
                0:       scale = 16'd1;
                1:       scale = 16'($urandom_range(1, 300));
                default: scale = 16'($urandom);
            endcase
            shift = 5'($urandom_range(0, 31));
            for (int k = 0; k < 40; k++) begin
                if (!stall && $urandom_range(0, 3) != 0) begin
                    foreach (a[i]) a[i] = ($urandom_range(0, 1) == 1) ? 32'($urandom)
                                          : 32'($urandom_range(0, 4000)) - 32'd2000;
                    issue(a, 1'b0, 64'd0);
                end else begin
                    idle();
                end
                out_ready = ($urandom_range(0, 3) != 0);
            end
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
